// File: rtl/mmu_dm_arbiter.sv
// mmu_dm_arbiter: shares the mmu data port between the CPU (port 0) and the debug/loader master (port 1).
module mmu_dm_arbiter #(
  parameter int POLICY     = 1,
  parameter int MAX_STREAK = 4
) (
  input  logic        clk_i,
  input  logic        resetb_i,
  input  logic        req0_i,
  input  logic        req1_i,
  input  logic        we0_i,
  input  logic        we1_i,
  input  logic [31:0] addr0_i,
  input  logic [31:0] addr1_i,
  input  logic [31:0] di0_i,
  input  logic [31:0] di1_i,
  input  logic [3:0]  be0_i,
  input  logic [3:0]  be1_i,
  input  logic        sgn0_i,
  input  logic        sgn1_i,
  input  logic        lock0_i,
  input  logic        lock1_i,
  output logic        gnt0_o,
  output logic        gnt1_o,
  output logic        rvalid0_o,
  output logic        rvalid1_o,
  output logic [31:0] rdata0_o,
  output logic [31:0] rdata1_o,
  output logic        dm_we_o,
  output logic [31:0] dm_addr_o,
  output logic [31:0] dm_di_o,
  output logic [3:0]  dm_be_o,
  output logic        is_signed_o,
  input  logic [31:0] dm_do_i
);
  localparam logic [3:0] MAX_S = 4'(MAX_STREAK);
  logic       last_win_q, last_win_d;
  logic [3:0] streak_q, streak_d;
  logic       lock_vld_q, lock_vld_d, lock_own_q, lock_own_d;
  logic       rd_vld_q, rd_vld_d, rd_tag_q, rd_tag_d;
  logic       lock_hit, win, gnt_any;
  always_comb begin
    lock_hit    = lock_vld_q & (lock_own_q ? req1_i : req0_i);
    // win selects port 1; with no request it stays 0 so the mux idles on port 0
    win         = lock_hit ? lock_own_q :
                  !(req0_i & req1_i) ? req1_i :
                  (POLICY == 0) ? ~last_win_q : (streak_q == MAX_S);
    gnt_any     = resetb_i & (req0_i | req1_i);
    gnt0_o      = gnt_any & ~win;
    gnt1_o      = gnt_any & win;
    dm_we_o     = win ? (we1_i & gnt1_o) : (we0_i & gnt0_o);
    dm_addr_o   = win ? addr1_i : addr0_i;
    dm_di_o     = win ? di1_i : di0_i;
    dm_be_o     = win ? be1_i : be0_i;
    is_signed_o = win ? sgn1_i : sgn0_i;
    last_win_d  = gnt_any ? win : last_win_q;
    streak_d    = (gnt0_o & req1_i) ? ((streak_q == MAX_S) ? streak_q : streak_q + 4'd1) : 4'd0;
    lock_vld_d  = gnt_any & (win ? lock1_i : lock0_i);
    lock_own_d  = win;
    rd_vld_d    = gnt_any & ~(win ? we1_i : we0_i);
    rd_tag_d    = win;
    rvalid0_o   = resetb_i & rd_vld_q & ~rd_tag_q;
    rvalid1_o   = resetb_i & rd_vld_q & rd_tag_q;
    rdata0_o    = rvalid0_o ? dm_do_i : 32'd0;
    rdata1_o    = rvalid1_o ? dm_do_i : 32'd0;
  end
  always_ff @(posedge clk_i) begin
    if (!resetb_i) begin
      last_win_q <= 1'b1;
      streak_q   <= 4'd0;
      lock_vld_q <= 1'b0;
      lock_own_q <= 1'b0;
      rd_vld_q   <= 1'b0;
      rd_tag_q   <= 1'b0;
    end else begin
      last_win_q <= last_win_d;
      streak_q   <= streak_d;
      lock_vld_q <= lock_vld_d;
      lock_own_q <= lock_own_d;
      rd_vld_q   <= rd_vld_d;
      rd_tag_q   <= rd_tag_d;
    end
  end
endmodule
